param_sync_ram_clr: RTL

//  Parametrised simple-dual-port synchronous RAM with separate write and read ports.

---
 rtl/ram_pkg.sv | 25 ++
 rtl/param_sync_ram_clr_if.sv | 24 ++
 rtl/ram_clear_seq.sv | 60 ++++++
 rtl/param_sync_ram_clr.sv | 129 ++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared definitions for the clearable simple-dual-port RAM: sweep FSM states,
// read-during-write mode constants and the read-result source selector.
package ram_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } clr_state_t;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    // Which value the read stage presents; the array output itself is never reset.
    typedef enum logic [1:0] {
        SRC_ZERO = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_CLR  = 2'd2,
        SRC_BYP  = 2'd3
    } rd_src_t;

    function automatic logic addr_ok(input logic [31:0] addr, input logic [31:0] depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/param_sync_ram_clr_if.sv
// Request/response bundle for param_sync_ram_clr: write port, read port and status.
interface param_sync_ram_clr_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
);
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data, rd_valid, busy
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data, rd_valid, busy
    );
endinterface

// File: rtl/ram_clear_seq.sv
// Post-reset zero-fill sequencer: walks every address once, then parks in READY.
module ram_clear_seq #(
    parameter int ADDR_W = 5,
    parameter int DEPTH  = 32
) (
    input  logic              clock,
    input  logic              reset,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);
    import ram_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    clr_state_t        r_state;
    clr_state_t        w_state_next;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        o_busy       = 1'b0;
        o_clr_we     = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                o_busy   = 1'b1;
                // No array write while reset is held; the sweep restarts at 0 anyway.
                o_clr_we = !reset;
                if (r_cnt == LAST_ADDR) begin
                    w_state_next = ST_READY;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            ST_READY: begin
                w_state_next = ST_READY;
            end
            default: begin
                w_state_next = ST_CLEAR;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_clr_addr = r_cnt;

endmodule

// File: rtl/param_sync_ram_clr.sv
// Simple-dual-port synchronous RAM with post-reset clear sweep, selectable
// read-during-write behaviour, optional output register and read-valid pulse.
module param_sync_ram_clr #(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 5,
    parameter int                DEPTH     = 32,
    parameter int                RDW_NEW   = 0,
    parameter int                OUT_REG   = 0,
    parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
    input  logic                  clock,
    input  logic                  reset,
    param_sync_ram_clr_if.slave   bus
);
    import ram_pkg::*;

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;

    ram_clear_seq #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_clear_seq (
        .clock      (clock),
        .reset      (reset),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    logic              w_wr_ok;
    logic              w_rd_ok;
    logic              w_usr_we;
    logic              w_rd_acc;
    logic              w_rdw_hit;
    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [DATA_W-1:0] w_mem_wdata;

    assign w_wr_ok   = addr_ok(32'(bus.wr_addr), 32'(DEPTH));
    assign w_rd_ok   = addr_ok(32'(bus.rd_addr), 32'(DEPTH));
    assign w_usr_we  = !w_busy && bus.wr_en && w_wr_ok;
    assign w_rd_acc  = !w_busy && bus.rd_en;
    assign w_rdw_hit = (RDW_NEW == ram_pkg::RDW_NEW) && w_usr_we
                       && (bus.wr_addr == bus.rd_addr);

    // The sweep owns the write port while busy; user writes are masked then.
    assign w_mem_we    = w_clr_we || w_usr_we;
    assign w_mem_waddr = w_clr_we ? w_clr_addr : bus.wr_addr;
    assign w_mem_wdata = w_clr_we ? CLEAR_VAL  : bus.wr_data;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_ram_q;

    always_ff @(posedge clock) begin
        if (w_mem_we) begin
            r_mem[w_mem_waddr] <= w_mem_wdata;
        end
        if (w_rd_acc && w_rd_ok) begin
            r_ram_q <= r_mem[bus.rd_addr];
        end
    end

    rd_src_t           r_src;
    logic [DATA_W-1:0] r_byp_data;
    logic              r_rd_hit;
    logic [DATA_W-1:0] w_stage_data;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_src      <= SRC_ZERO;
            r_byp_data <= '0;
            r_rd_hit   <= 1'b0;
        end else begin
            r_rd_hit <= w_rd_acc;
            if (w_rd_acc) begin
                if (!w_rd_ok) begin
                    r_src <= SRC_CLR;
                end else if (w_rdw_hit) begin
                    r_src      <= SRC_BYP;
                    r_byp_data <= bus.wr_data;
                end else begin
                    r_src <= SRC_RAM;
                end
            end
        end
    end

    // Selector registers only move on an accepted read, so the result holds.
    always_comb begin
        w_stage_data = '0;
        case (r_src)
            SRC_ZERO: w_stage_data = '0;
            SRC_RAM:  w_stage_data = r_ram_q;
            SRC_CLR:  w_stage_data = CLEAR_VAL;
            SRC_BYP:  w_stage_data = r_byp_data;
            default:  w_stage_data = '0;
        endcase
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] r_out_data;
            logic              r_out_valid;

            always_ff @(posedge clock) begin
                if (reset) begin
                    r_out_data  <= '0;
                    r_out_valid <= 1'b0;
                end else begin
                    r_out_valid <= r_rd_hit;
                    if (r_rd_hit) begin
                        r_out_data <= w_stage_data;
                    end
                end
            end

            assign bus.rd_data  = r_out_data;
            assign bus.rd_valid = r_out_valid;
        end else begin : g_no_out_reg
            assign bus.rd_data  = w_stage_data;
            assign bus.rd_valid = r_rd_hit;
        end
    endgenerate

    assign bus.busy = w_busy;

endmodule
